// File: rtl/conv_scan_ctrl_pkg.sv
// Shared geometry and FSM encoding for the conv scan sequencer.
// The dense and image-memory blocks import the same constants so that all three agree on them.
package conv_scan_ctrl_pkg;
    localparam int IMG_W       = 14;
    localparam int IMG_H       = 14;
    localparam int PAIR_OFFSET = 2;
    localparam int NUM_CH      = 16;
    localparam int ADDR_W      = 8;
    localparam int MEM_LAT     = 1;
    localparam int IDX_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_e;
endpackage

// File: rtl/conv_scan_ctrl_scan_counter.sv
// Cascaded channel/col/row counter for the scan.
// The paired addresses are tracked incrementally, so no multiplier is needed.
module conv_scan_ctrl_scan_counter
    import conv_scan_ctrl_pkg::*;
#(
    parameter int IMG_W_P   = IMG_W,
    parameter int IMG_H_P   = IMG_H,
    parameter int PAIR_P    = PAIR_OFFSET,
    parameter int NUM_CH_P  = NUM_CH,
    parameter int ADDR_W_P  = ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                step,
    output logic [IDX_W-1:0]    row,
    output logic [IDX_W-1:0]    col,
    output logic [IDX_W-1:0]    channel,
    output logic [ADDR_W_P-1:0] addr1,
    output logic [ADDR_W_P-1:0] addr2,
    output logic                at_end
);
    localparam int COL_MAX = IMG_W_P - 1 - PAIR_P;

    logic [IDX_W-1:0]    row_q, row_d, col_q, col_d, ch_q, ch_d;
    logic [ADDR_W_P-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic                ch_wrap, col_wrap;

    assign ch_wrap  = (ch_q == IDX_W'(NUM_CH_P - 1));
    assign col_wrap = (col_q == IDX_W'(COL_MAX));
    assign at_end   = ch_wrap & col_wrap & (row_q == IDX_W'(IMG_H_P - 1));

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        ch_d    = ch_q;
        addr1_d = addr1_q;
        if (clear) begin
            row_d   = '0;
            col_d   = '0;
            ch_d    = '0;
            addr1_d = '0;
        end else if (step && !at_end) begin
            if (!ch_wrap) begin
                ch_d = ch_q + IDX_W'(1);
            end else begin
                ch_d = '0;
                if (!col_wrap) begin
                    col_d   = col_q + IDX_W'(1);
                    addr1_d = addr1_q + ADDR_W_P'(1);
                end else begin
                    // Row wrap also steps over the excluded tail columns.
                    col_d   = '0;
                    row_d   = row_q + IDX_W'(1);
                    addr1_d = addr1_q + ADDR_W_P'(PAIR_P + 1);
                end
            end
        end
        addr2_d = addr1_d + ADDR_W_P'(PAIR_P);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
            addr1_q <= '0;
            addr2_q <= ADDR_W_P'(PAIR_P);
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign channel = ch_q;
    assign addr1   = addr1_q;
    assign addr2   = addr2_q;
endmodule

// File: rtl/conv_scan_ctrl.sv
// Scan sequencer: the start/done FSM and the valid/ready handshake around the scan counter.
// Memory reads are drained for MEM_LAT cycles before done pulses.
module conv_scan_ctrl
    import conv_scan_ctrl_pkg::*;
#(
    parameter int IMG_W_P  = IMG_W,
    parameter int IMG_H_P  = IMG_H,
    parameter int PAIR_P   = PAIR_OFFSET,
    parameter int NUM_CH_P = NUM_CH,
    parameter int ADDR_W_P = ADDR_W,
    parameter int MEM_LAT_P = MEM_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                ready,
    output logic                valid,
    output logic [IDX_W-1:0]    row,
    output logic [IDX_W-1:0]    col,
    output logic [IDX_W-1:0]    channel,
    output logic [ADDR_W_P-1:0] addr1,
    output logic [ADDR_W_P-1:0] addr2,
    output logic                load,
    output logic                last,
    output logic                busy,
    output logic                done
);
    localparam int DRAIN_W = (MEM_LAT_P > 1) ? $clog2(MEM_LAT_P) : 1;

    scan_state_e        state_q, state_d;
    logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               clear, step, at_end;

    conv_scan_ctrl_scan_counter #(
        .IMG_W_P  (IMG_W_P),
        .IMG_H_P  (IMG_H_P),
        .PAIR_P   (PAIR_P),
        .NUM_CH_P (NUM_CH_P),
        .ADDR_W_P (ADDR_W_P)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (clear),
        .step    (step),
        .row     (row),
        .col     (col),
        .channel (channel),
        .addr1   (addr1),
        .addr2   (addr2),
        .at_end  (at_end)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        clear   = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SCAN;
                    clear   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (valid_q && ready) begin
                    step = 1'b1;
                    if (at_end) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (drain_q == DRAIN_W'(MEM_LAT_P - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        valid_d = (state_d == ST_SCAN);
        busy_d  = (state_d == ST_SCAN) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign load  = valid_q & ready;
    assign last  = at_end & valid_q;
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench for conv_scan_ctrl: stimulus queues the expected beats, and a negedge monitor
// pops one expected beat for every beat the DUT loads and compares the two.
module tb_conv_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, abort, ready;
    logic       valid, load, last, busy, done;
    logic [4:0] row, col, channel;
    logic [7:0] addr1, addr2;

    typedef logic [31:0] beat_t;
    beat_t exp_q[$];
    int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
    int load_cnt = 0, run_base = 0, run_id = 0;

    conv_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
        .valid(valid), .row(row), .col(col), .channel(channel),
        .addr1(addr1), .addr2(addr2), .load(load), .last(last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference beat i: channel innermost, 12 columns per row, addresses from row*14+col.
    function automatic beat_t model_beat(int i);
        int ch, c, r, a;
        ch = i % 16;
        c  = (i / 16) % 12;
        r  = i / 192;
        a  = r * 14 + c;
        return {5'(r), 5'(c), 5'(ch), 8'(a), 8'(a + 2), (i == 2687)};
    endfunction

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_beat(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(input logic [4:0] r, input logic [4:0] c, input logic [4:0] ch,
                             input string nm);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            tick();
            if (valid && row == r && col == c && channel == ch) found = 1'b1;
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    always @(negedge clk) begin
        beat_t act;
        int    idx;
        cyc++;
        if (rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (load) begin
                act = {row, col, channel, addr1, addr2, last};
                idx = load_cnt - run_base;
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", act, 32'hffff_ffff);
                end else begin
                    chk("beat", act, exp_q.pop_front());
                end
                if (last) last_cyc = cyc;
                if (run_id == 1) begin
                    if (idx == 0)    chk("first_beat", act, {5'd0, 5'd0, 5'd0, 8'd0, 8'd2, 1'b0});
                    if (idx == 16)   chk("beat16", act, {5'd0, 5'd1, 5'd0, 8'd1, 8'd3, 1'b0});
                    if (idx == 191)  chk("row0_end", act, {5'd0, 5'd11, 5'd15, 8'd11, 8'd13, 1'b0});
                    if (idx == 192)  chk("row_wrap", act, {5'd1, 5'd0, 5'd0, 8'd14, 8'd16, 1'b0});
                    if (idx == 2687) chk("last_beat", act, {5'd13, 5'd11, 5'd15, 8'd193, 8'd195, 1'b1});
                end
                load_cnt++;
            end
        end
    end

    initial begin
        logic found;
        rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;

        // Reset, then sit idle
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr1", 32'(addr1), 32'd0);
        chk("rst_addr2", 32'(addr2), 32'd2);
        chk("rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b1;
        repeat (20) tick();
        chk("idle_no_done", 32'(done_cnt), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);

        // Run 1: full scan with ready high; a stray start mid-scan must be ignored
        push_beats(2688);
        run_base = load_cnt;
        run_id = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_first_valid", 32'({valid, busy, addr1}), 32'({1'b1, 1'b1, 8'd0}));
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            tick();
            if (done_cnt >= 1) found = 1'b1;
        end
        chk("r1_done_seen", 32'(found), 32'd1);
        repeat (3) tick();
        chk("r1_load_count", 32'(load_cnt - run_base), 32'd2688);
        chk("r1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("r1_done_count", 32'(done_cnt), 32'd1);
        chk("r1_done_latency", 32'(done_cyc - last_cyc), 32'd2);
        chk("r1_hold", {row, col, channel, addr1, 4'd0, valid, busy, last},
            {5'd13, 5'd11, 5'd15, 8'd193, 4'd0, 1'b0, 1'b0, 1'b0});
        run_id = 2;

        // Run 2: backpressure at row2/col3/ch7, then abort at row5/col4/ch0
        push_beats(1025);
        run_base = load_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beat(5'd2, 5'd3, 5'd7, "bp_reach");
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_addr1", 32'(addr1), 32'd31);
            chk("bp_channel", 32'(channel), 32'd7);
            chk("bp_load", 32'(load), 32'd0);
        end
        tick();
        ready = 1'b1;
        tick();
        chk("bp_resume", {channel, addr1}, {5'd8, 8'd31});
        wait_beat(5'd5, 5'd4, 5'd0, "abort_reach");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd1);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'({valid, busy}), 32'd0);
        repeat (2) tick();

        // Run 3: restart from zero, then async reset between edges at row 7
        push_beats(1345);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r3_restart", {row, col, channel, addr1, 8'd0, valid},
            {5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 1'b1});
        wait_beat(5'd7, 5'd0, 5'd0, "row7_reach");
        #6;
        rst = 1'b0;
        #1;
        chk("async_rst", {row, col, channel, addr1, addr2, 4'd0},
            {5'd0, 5'd0, 5'd0, 8'd0, 8'd2, 4'd0});
        chk("async_rst_flags", 32'({valid, busy, load, last, done}), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("rst_no_done", 32'(done_cnt), 32'd1);
        chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rst_idle_valid", 32'(valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
- Sequencer for the dense/image-memory datapath: walks row, column and channel counters over a 2-D feature map.
- Drives the paired read addresses (addr1, addr2 = addr1 + PAIR_OFFSET) into image memory and the matching row/col/channel indices into the dense stage.
- Start/done handshake toward the layer controller; valid/ready backpressure toward the consumer.
- Replaces the free-running, always-enabled addressing currently wired at top level.

Parameters:
- IMG_W, 14: feature-map width in pixels.
- IMG_H, 14: feature-map height in pixels.
- PAIR_OFFSET, 2: address distance from addr1 to addr2.
- NUM_CH, 16: output channels per position (OC+1).
- ADDR_W, 8: memory address width. Requires IMG_W*IMG_H <= 2^ADDR_W.
- MEM_LAT, 1: image-memory read latency in cycles, drained before done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin scan; sampled only in IDLE.
- abort  in  1  terminate scan, return to IDLE; no done pulse.
- ready  in  1  consumer accepts the current beat.
- valid  out  1  row/col/channel/addr1/addr2 are a live beat.
- row  out  5  current row index.
- col  out  5  current column index.
- channel  out  5  current channel index.
- addr1  out  ADDR_W  row*IMG_W + col.
- addr2  out  ADDR_W  addr1 + PAIR_OFFSET.
- load  out  1  memory read enable; equals valid & ready.
- last  out  1  current beat is the final beat of the scan.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (rst=0, async): state=IDLE. row, col, channel, addr1 = 0; addr2 = PAIR_OFFSET. valid, load, last, busy, done = 0. Drain counter = 0.
- Column range: 0..COL_MAX, where COL_MAX = IMG_W-1-PAIR_OFFSET, so both addresses stay in-row. Defaults give COL_MAX = 11.
- Scan order: channel innermost, then col, then row. Total beats = IMG_H*(COL_MAX+1)*NUM_CH; 2688 at defaults.
- FSM states:
  - IDLE: start=1 -> SCAN. Counters cleared to 0; valid=1 from the next cycle.
  - SCAN: beat advances only when valid & ready.
    - Channel increments; at NUM_CH-1 it wraps to 0 and col increments.
    - At COL_MAX, col wraps to 0 and row increments.
    - If ready=0, all outputs hold stable.
    - Accepted beat with last=1 -> DRAIN; valid drops the same edge.
  - DRAIN: counts MEM_LAT cycles, then -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. Counters hold final values until the next start.
- Address arithmetic: addr1 is registered and updated incrementally with the counters, not by multiplication.
  - +1 on column step.
  - +PAIR_OFFSET+1 on row wrap, skipping the excluded tail columns.
  - Must equal row*IMG_W+col at every beat. addr2 is registered alongside as addr1+PAIR_OFFSET.
- last = (row==IMG_H-1) & (col==COL_MAX) & (channel==NUM_CH-1) & valid.
- load is combinational: valid & ready.
- start outside IDLE is ignored.
- abort has priority over all transitions in SCAN/DRAIN/DONE: next state IDLE, valid=0, no done pulse. abort in IDLE has no effect.
- start and abort both high in IDLE: abort wins and the state stays IDLE.
- Reset mid-scan: immediate return to reset values. No done pulse.

Decomposition:
- Shared package: FSM state encoding (IDLE, SCAN, DRAIN, DONE) and the geometry constants (IMG_W, IMG_H, PAIR_OFFSET, NUM_CH), so dense, imgMem and this block agree.
- One natural sub-module: scan_counter, a cascaded channel/col/row counter with wrap flags and incremental address update. The FSM and handshake stay in conv_scan_ctrl.

Test Plan:
- Reset then idle: rst low for 3 cycles, start=0 -> valid=0, busy=0, addr1=0, addr2=2, done never asserted over 20 cycles.
- Full scan with ready tied 1: start pulse -> first beat row0/col0/ch0, addr1=0, addr2=2. After 16 beats col=1, addr1=1. Last beat row13/col11/ch15, addr1=193, addr2=195, last=1. Exactly 2688 load cycles, then done pulses 1 cycle after DRAIN (MEM_LAT=1).
- Row wrap: at row0/col11/ch15 accepted -> next beat row1/col0/ch0, addr1=14, addr2=16.
- Backpressure: ready low for 5 cycles at row2/col3/ch7 -> outputs hold addr1=31, channel=7. load=0 throughout; resumes at ch8 when ready returns high.
- Abort: abort=1 at row5/col4/ch0 -> next cycle IDLE, valid=0, busy=0, no done. A new start restarts at addr1=0.
- Async reset mid-scan: rst low between clock edges at row7 -> outputs reach reset values immediately, before the next edge. No done pulse after release.
